// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared constants and fetch state type for the instruction fetch unit
package ysyx_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - instruction fetch unit: owns the PC, fetches one word at a time,
// hands it to decode and honours redirects by squashing obsolete fetches
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_drop;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic         r_inst_err;

  logic [31:0]  w_redirect_pc;
  logic         w_inst_fire;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign req_valid     = (r_state == REQ) && !rst;
  assign req_addr      = r_pc;
  assign inst_valid    = (r_state == HOLD) && !redirect_valid;
  assign w_inst_fire   = inst_valid && inst_ready;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_err      = r_inst_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_inst     <= NOP_INST;
      r_inst_pc  <= RESET_PC;
      r_inst_err <= 1'b0;
    end else begin
      case (r_state)
        REQ: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            // A request accepted alongside the redirect fetched the old PC.
            if (req_ready) begin
              r_state <= WAIT;
              r_drop  <= 1'b1;
            end
          end else if (req_ready) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (resp_valid) begin
              r_state <= REQ;
              r_drop  <= 1'b0;
            end else begin
              r_drop  <= 1'b1;
            end
          end else if (resp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_inst     <= resp_data;
              r_inst_pc  <= r_pc;
              r_inst_err <= resp_err;
              r_state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= REQ;
          end else if (w_inst_fire) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

endmodule
